// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared IR types and carrier timing helpers
package ir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2
  } ir_state_t;

  function automatic int carrier_period(input int clk_hz, input int carrier_hz);
    return clk_hz / carrier_hz;
  endfunction

  function automatic int carrier_high(input int period, input int duty_pct);
    return (period * duty_pct) / 100;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ir_carrier_modulator_if.sv
// rtl/ir_carrier_modulator_if.sv - enable request and LED/status outputs of the modulator
interface ir_carrier_modulator_if;
  logic enable_in;
  logic ir_led_out;
  logic busy;
  logic burst_done;

  modport master (output enable_in, input ir_led_out, input busy, input burst_done);
  modport slave  (input enable_in, output ir_led_out, output busy, output burst_done);
endinterface

// File: rtl/ir_carrier_phase_counter.sv
// rtl/ir_carrier_phase_counter.sv - free-running carrier phase within one period
module ir_carrier_phase_counter #(
  parameter int PERIOD  = 10,
  parameter int PHASE_W = $clog2(PERIOD)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               run,
  output logic [PHASE_W-1:0] phase,
  output logic               wrap
);

  assign wrap = (phase == PHASE_W'(PERIOD - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      phase <= '0;
    end else if (run) begin
      phase <= wrap ? '0 : phase + 1'b1;
    end
  end

endmodule

// File: rtl/ir_carrier_modulator.sv
// rtl/ir_carrier_modulator.sv - gated IR carrier with whole-period bursts and minimum mark/space
module ir_carrier_modulator
  import ir_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int CARRIER_HZ    = 38_000,
  parameter int DUTY_PCT      = 33,
  parameter int MIN_MARK_PER  = 10,
  parameter int MIN_SPACE_PER = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  ir_carrier_modulator_if.slave  bus
);

  localparam int PERIOD  = carrier_period(CLK_HZ, CARRIER_HZ);
  localparam int HIGH    = carrier_high(PERIOD, DUTY_PCT);
  localparam int CNT_MAX = max2(MIN_MARK_PER, MIN_SPACE_PER);
  localparam int PHASE_W = $clog2(PERIOD);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W:0]   MARK_TGT  = (CNT_W + 1)'(MIN_MARK_PER);
  localparam logic [CNT_W:0]   SPACE_TGT = (CNT_W + 1)'(MIN_SPACE_PER);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);

  if (PERIOD < 2) begin : g_bad_period
    $error("ir_carrier_modulator: carrier period must be at least 2 clocks");
  end
  if (HIGH < 1 || HIGH > PERIOD - 1) begin : g_bad_duty
    $error("ir_carrier_modulator: carrier high time must be within 1..PERIOD-1");
  end
  if (MIN_MARK_PER < 1 || MIN_SPACE_PER < 1) begin : g_bad_min
    $error("ir_carrier_modulator: minimum mark/space must be at least one period");
  end

  ir_state_t          state;
  ir_state_t          state_nxt;
  logic [CNT_W-1:0]   per_cnt;
  logic [CNT_W-1:0]   per_cnt_nxt;
  logic [CNT_W-1:0]   cnt_step;
  logic [CNT_W:0]     periods_done;
  logic [PHASE_W-1:0] phase;
  logic               wrap;

  // Phase is held at zero while idle so every burst starts on a fresh period.
  ir_carrier_phase_counter #(
    .PERIOD  (PERIOD),
    .PHASE_W (PHASE_W)
  ) u_phase (
    .clk   (clk),
    .reset (reset),
    .clr   (state == ST_IDLE),
    .run   (state != ST_IDLE),
    .phase (phase),
    .wrap  (wrap)
  );

  // Periods finished once the current wrap completes; one bit wider so it cannot overflow.
  assign periods_done = {1'b0, per_cnt} + 1'b1;
  assign cnt_step     = (per_cnt == CNT_SAT) ? per_cnt : per_cnt + 1'b1;

  always_comb begin
    state_nxt   = state;
    per_cnt_nxt = per_cnt;
    case (state)
      ST_IDLE: begin
        if (bus.enable_in) begin
          state_nxt   = ST_MARK;
          per_cnt_nxt = '0;
        end
      end
      ST_MARK: begin
        if (wrap) begin
          if (!bus.enable_in && (periods_done >= MARK_TGT)) begin
            state_nxt   = ST_SPACE;
            per_cnt_nxt = '0;
          end else begin
            per_cnt_nxt = cnt_step;
          end
        end
      end
      ST_SPACE: begin
        if (wrap) begin
          if (periods_done >= SPACE_TGT) begin
            state_nxt   = bus.enable_in ? ST_MARK : ST_IDLE;
            per_cnt_nxt = '0;
          end else begin
            per_cnt_nxt = cnt_step;
          end
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        per_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      per_cnt <= '0;
    end else begin
      state   <= state_nxt;
      per_cnt <= per_cnt_nxt;
    end
  end

  assign bus.ir_led_out = (state == ST_MARK) && (phase < PHASE_W'(HIGH));
  assign bus.busy       = (state != ST_IDLE);
  assign bus.burst_done = (state == ST_MARK) && wrap && (state_nxt != ST_MARK);

endmodule

// File: tb/tb_ir_carrier_modulator.sv
// tb/tb_ir_carrier_modulator.sv - directed and randomized checks against a behavioural carrier model
module tb_ir_carrier_modulator;

  localparam int P  = 10;
  localparam int H  = 3;
  localparam int MM = 2;
  localparam int MS = 2;
  localparam int DP = 1315;
  localparam int DH = 433;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_d = 1'b1;

  always #5 clk = ~clk;

  ir_carrier_modulator_if ifs ();
  ir_carrier_modulator_if ifd ();

  ir_carrier_modulator #(
    .CLK_HZ        (1000),
    .CARRIER_HZ    (100),
    .DUTY_PCT      (30),
    .MIN_MARK_PER  (MM),
    .MIN_SPACE_PER (MS)
  ) dut_s (
    .clk   (clk),
    .reset (rst),
    .bus   (ifs)
  );

  ir_carrier_modulator dut_d (
    .clk   (clk),
    .reset (rst_d),
    .bus   (ifd)
  );

  int checks = 0;
  int failures = 0;

  // Model: mode 0 idle, 1 mark, 2 space; t counts clocks since the mode was entered.
  int   m_mode = 0;
  int   m_t = 0;
  bit   m_valid = 1'b0;
  logic o_led, o_busy, o_done;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic en, input logic r, input string tag);
    logic e_led, e_busy, e_done;
    @(negedge clk);
    rst = r;
    ifs.enable_in = en;
    #1;
    o_led  = ifs.ir_led_out;
    o_busy = ifs.busy;
    o_done = ifs.burst_done;
    if (m_valid) begin
      e_led  = (m_mode == 1) && ((m_t % P) < H);
      e_busy = (m_mode != 0);
      e_done = (m_mode == 1) && ((m_t % P) == P - 1) && !en && ((m_t / P + 1) >= MM);
      check_bit({tag, "_led"}, o_led, e_led);
      check_bit({tag, "_busy"}, o_busy, e_busy);
      check_bit({tag, "_done"}, o_done, e_done);
    end
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_t = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      case (m_mode)
        0: if (en) begin m_mode = 1; m_t = 0; end
        1: if (((m_t % P) == P - 1) && !en && ((m_t / P + 1) >= MM)) begin
             m_mode = 2; m_t = 0;
           end else m_t++;
        default: if (m_t == MS * P - 1) begin
             m_mode = en ? 1 : 0; m_t = 0;
           end else m_t++;
      endcase
    end
  endtask

  initial begin
    int hi, bz, dn, led_at, gap;
    logic en_r;
    int n, first_rise, last_rise, mark_len;
    logic prev, seen_done;

    ifs.enable_in = 1'b0;
    ifd.enable_in = 1'b0;

    // 1: reset overrides enable, then 1-clk latency to first LED high
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, "t1_rst");
    check_bit("t1_rst_led", o_led, 1'b0);
    check_bit("t1_rst_busy", o_busy, 1'b0);
    cyc(1'b1, 1'b0, "t1_rel1");
    check_bit("t1_first_clk_led", o_led, 1'b0);
    cyc(1'b1, 1'b0, "t1_rel2");
    check_bit("t1_second_clk_led", o_led, 1'b1);

    // 2: 45-clk enable -> 5 periods, 20 clks of space
    cyc(1'b0, 1'b1, "t2_rst");
    hi = 0; bz = 0; dn = 0;
    for (int k = 1; k <= 85; k++) begin
      cyc(k <= 45, 1'b0, "t2");
      hi += int'(o_led); bz += int'(o_busy); dn += int'(o_done);
    end
    check_int("t2_high_clks", hi, 15);
    check_int("t2_busy_clks", bz, 70);
    check_int("t2_done_pulses", dn, 1);

    // 3: single-clock pulse stretched to the minimum mark
    hi = 0; bz = 0; dn = 0;
    for (int k = 1; k <= 51; k++) begin
      cyc(k == 1, 1'b0, "t3");
      hi += int'(o_led); bz += int'(o_busy); dn += int'(o_done);
    end
    check_int("t3_high_clks", hi, 6);
    check_int("t3_busy_clks", bz, 40);
    check_int("t3_done_pulses", dn, 1);
    check_bit("t3_idle_busy", o_busy, 1'b0);

    // 4: enable rising during space is held off until the final space wrap
    hi = 0; gap = 0; led_at = 0;
    for (int k = 1; k <= 60; k++) begin
      cyc((k == 1) || (k >= 26), 1'b0, "t4");
      if (k >= 22 && k <= 41) hi += int'(o_led);
      if (k >= 2 && k <= 42 && !o_busy) gap++;
      if (k == 42) led_at = int'(o_led);
    end
    check_int("t4_space_led", hi, 0);
    check_int("t4_idle_gap", gap, 0);
    check_int("t4_mark_restart", led_at, 1);
    for (int k = 0; k < 70; k++) cyc(1'b0, 1'b0, "t4_drain");

    // 5: reset at MARK phase 1 aborts; restart from phase 0
    cyc(1'b1, 1'b0, "t5_a");
    cyc(1'b1, 1'b0, "t5_b");
    cyc(1'b1, 1'b1, "t5_rst");
    hi = 0; led_at = 0;
    for (int k = 4; k <= 40; k++) begin
      cyc(k <= 14, 1'b0, "t5");
      if (k == 4) begin
        check_bit("t5_abort_led", o_led, 1'b0);
        check_bit("t5_abort_busy", o_busy, 1'b0);
      end
      if (k == 5) led_at = int'(o_led);
      if (k >= 5 && k <= 14) hi += int'(o_led);
    end
    check_int("t5_restart_led", led_at, 1);
    check_int("t5_restart_high", hi, 3);
    for (int k = 0; k < 40; k++) cyc(1'b0, 1'b0, "t5_drain");

    // Randomized enable runs with occasional resets
    en_r = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(7, 0) == 0) en_r = ~en_r;
      cyc(en_r, ($urandom_range(199, 0) == 0), "rnd");
    end

    // 6: default parameters, long enable
    rst = 1'b1;
    @(negedge clk); rst_d = 1'b1; ifd.enable_in = 1'b0;
    @(negedge clk); rst_d = 1'b0;
    prev = 1'b0; first_rise = -1; last_rise = -1; seen_done = 1'b0; mark_len = 0;
    for (n = 0; n < 30000 && !seen_done; n++) begin
      @(negedge clk);
      ifd.enable_in = (n < 20000);
      #1;
      if (ifd.ir_led_out && !prev) begin
        if (last_rise >= 0) check_int("t6_period", n - last_rise, DP);
        else first_rise = n;
        last_rise = n;
      end
      if (!ifd.ir_led_out && prev && last_rise >= 0) check_int("t6_high", n - last_rise, DH);
      if (ifd.burst_done && n >= 20000) begin
        seen_done = 1'b1;
        mark_len = n - first_rise + 1;
      end
      prev = ifd.ir_led_out;
    end
    check_int("t6_done_seen", int'(seen_done), 1);
    check_int("t6_len_multiple", mark_len % DP, 0);
    check_int("t6_len_min", int'(mark_len >= 10 * DP), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
